// File: rtl/keypad_matrix_scanner_if.sv
// Keypad scanner bundle: raw row lines toward the scanner, column strobes and
// decoded key information toward the pins and the operand-entry logic.
interface keypad_matrix_scanner_if #(
    parameter int NUM_COLS = 4,
    parameter int NUM_ROWS = 4
);
    localparam int CW = $clog2(NUM_COLS);
    localparam int RW = $clog2(NUM_ROWS);

    logic [NUM_ROWS-1:0] row_in;
    logic [NUM_COLS-1:0] col_drive;
    logic [CW-1:0]       column_index;
    logic [CW+RW-1:0]    key_code;
    logic                key_valid;
    logic                key_held;
    logic                multi_key;

    modport master (
        input  row_in,
        output col_drive, column_index, key_code, key_valid, key_held, multi_key
    );

    modport slave (
        output row_in,
        input  col_drive, column_index, key_code, key_valid, key_held, multi_key
    );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// Keypad matrix scanner: one-hot column strobing with per-column dwell, a
// two-flop row synchroniser, press/release debounce, {column,row} key-code
// encoding and multi-key flagging. All outputs are registered.
module keypad_matrix_scanner #(
    parameter int NUM_COLS       = 4,
    parameter int NUM_ROWS       = 4,
    parameter int DWELL          = 3,
    parameter int DEBOUNCE       = 10,
    parameter int ROW_ACTIVE_LOW = 0
) (
    input  logic                    slow_clk,
    input  logic                    rst,
    keypad_matrix_scanner_if.master kp
);
    localparam int CW      = $clog2(NUM_COLS);
    localparam int RW      = $clog2(NUM_ROWS);
    localparam int CNT_MAX = (DWELL > DEBOUNCE) ? DWELL : DEBOUNCE;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0]    DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0]    DEB_LAST   = CNT_W'(DEBOUNCE - 1);
    localparam logic [NUM_ROWS-1:0] ROW_IDLE   = (ROW_ACTIVE_LOW != 0) ?
                                                 {NUM_ROWS{1'b1}} : {NUM_ROWS{1'b0}};

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Index of the lowest active row; a snapshot is never empty when used.
    function automatic logic [RW-1:0] lowest_set(input logic [NUM_ROWS-1:0] v);
        logic [RW-1:0] idx;
        idx = {RW{1'b0}};
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = RW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // True when more than one bit is set (clearing the lowest set bit leaves something).
    function automatic logic more_than_one(input logic [NUM_ROWS-1:0] v);
        return (v & (v - {{(NUM_ROWS-1){1'b0}}, 1'b1})) != {NUM_ROWS{1'b0}};
    endfunction

    // Next column index, wrapping the last column back to column 0.
    function automatic logic [CW-1:0] next_index(input logic [CW-1:0] idx);
        if (idx == CW'(NUM_COLS - 1)) begin
            return {CW{1'b0}};
        end else begin
            return idx + CW'(1);
        end
    endfunction

    logic [NUM_ROWS-1:0] sync1_r;
    logic [NUM_ROWS-1:0] sync2_r;
    logic [NUM_ROWS-1:0] rows_s;
    logic                hit_s;
    state_t              state_r;
    logic [CNT_W-1:0]    dwell_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [NUM_ROWS-1:0] snap_r;
    logic [NUM_COLS-1:0] col_drive_r;
    logic [CW-1:0]       column_index_r;
    logic [CW+RW-1:0]    key_code_r;
    logic                key_valid_r;
    logic                key_held_r;
    logic                multi_key_r;

    // Normalise synchronised rows to active-high and detect any pressed row.
    always_comb begin
        rows_s = (ROW_ACTIVE_LOW != 0) ? ~sync2_r : sync2_r;
        hit_s  = |rows_s;
    end

    // Synchroniser, scan/debounce/held/release sequencing and registered outputs.
    always_ff @(posedge slow_clk) begin
        if (!rst) begin
            sync1_r        <= ROW_IDLE;
            sync2_r        <= ROW_IDLE;
            state_r        <= ST_SCAN;
            dwell_r        <= {CNT_W{1'b0}};
            cnt_r          <= {CNT_W{1'b0}};
            snap_r         <= {NUM_ROWS{1'b0}};
            col_drive_r    <= {{(NUM_COLS-1){1'b0}}, 1'b1};
            column_index_r <= {CW{1'b0}};
            key_code_r     <= {(CW+RW){1'b0}};
            key_valid_r    <= 1'b0;
            key_held_r     <= 1'b0;
            multi_key_r    <= 1'b0;
        end else begin
            sync1_r     <= kp.row_in;
            sync2_r     <= sync1_r;
            key_valid_r <= 1'b0;
            case (state_r)
                ST_SCAN: begin
                    if (dwell_r != DWELL_LAST) begin
                        dwell_r <= dwell_r + CNT_W'(1);
                    end else if (hit_s) begin
                        // Column stays frozen while the snapshot is confirmed.
                        snap_r  <= rows_s;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_DEBOUNCE;
                    end else begin
                        col_drive_r    <= {col_drive_r[NUM_COLS-2:0], col_drive_r[NUM_COLS-1]};
                        column_index_r <= next_index(column_index_r);
                        dwell_r        <= {CNT_W{1'b0}};
                    end
                end
                ST_DEBOUNCE: begin
                    if (rows_s != snap_r) begin
                        // Pattern moved: rescan the same column from a fresh dwell.
                        dwell_r <= {CNT_W{1'b0}};
                        state_r <= ST_SCAN;
                    end else if (cnt_r == DEB_LAST) begin
                        key_code_r  <= {column_index_r, lowest_set(snap_r)};
                        multi_key_r <= more_than_one(snap_r);
                        key_valid_r <= 1'b1;
                        key_held_r  <= 1'b1;
                        state_r     <= ST_HELD;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!hit_s) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_RELEASE;
                    end else begin
                        state_r <= ST_HELD;
                    end
                end
                ST_RELEASE: begin
                    if (hit_s) begin
                        // Release glitch: back to held without a fresh pulse.
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_HELD;
                    end else if (cnt_r == DEB_LAST) begin
                        key_held_r     <= 1'b0;
                        multi_key_r    <= 1'b0;
                        col_drive_r    <= {col_drive_r[NUM_COLS-2:0], col_drive_r[NUM_COLS-1]};
                        column_index_r <= next_index(column_index_r);
                        dwell_r        <= {CNT_W{1'b0}};
                        state_r        <= ST_SCAN;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    dwell_r <= {CNT_W{1'b0}};
                    state_r <= ST_SCAN;
                end
            endcase
        end
    end

    assign kp.col_drive    = col_drive_r;
    assign kp.column_index = column_index_r;
    assign kp.key_code     = key_code_r;
    assign kp.key_valid    = key_valid_r;
    assign kp.key_held     = key_held_r;
    assign kp.multi_key    = multi_key_r;
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a default 4x4 instance checked against a
// behavioural keypad/scanner model plus scenario checks, and a 3x5 active-low
// instance checked for column wrap and row decode.
module tb_keypad_matrix_scanner;
    localparam int DWELL    = 3;
    localparam int DEBOUNCE = 10;

    logic slow_clk = 1'b0;
    logic rst      = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    always #5 slow_clk = ~slow_clk;

    keypad_matrix_scanner_if #(.NUM_COLS(4), .NUM_ROWS(4)) kp0 ();
    keypad_matrix_scanner_if #(.NUM_COLS(3), .NUM_ROWS(5)) kp1 ();

    keypad_matrix_scanner #(.NUM_COLS(4), .NUM_ROWS(4), .DWELL(DWELL),
                            .DEBOUNCE(DEBOUNCE), .ROW_ACTIVE_LOW(0))
        dut0 (.slow_clk(slow_clk), .rst(rst), .kp(kp0));

    keypad_matrix_scanner #(.NUM_COLS(3), .NUM_ROWS(5), .DWELL(DWELL),
                            .DEBOUNCE(DEBOUNCE), .ROW_ACTIVE_LOW(1))
        dut1 (.slow_clk(slow_clk), .rst(rst), .kp(kp1));

    // Physical keypads: keysN[c] is the mask of pressed rows in column c.
    logic [3:0] keys0 [4];
    logic [4:0] keys1 [3];
    logic [3:0] act0;
    logic [4:0] act1;

    // A pressed key connects its row to the driven column.
    always_comb begin
        act0 = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            if (kp0.col_drive[c] === 1'b1) act0 = act0 | keys0[c];
        end
        act1 = 5'b00000;
        for (int c = 0; c < 3; c++) begin
            if (kp1.col_drive[c] === 1'b1) act1 = act1 | keys1[c];
        end
    end
    assign kp0.row_in = act0;
    assign kp1.row_in = ~act1;

    // ---------------- behavioural reference model (4x4, active-high) ----------
    typedef enum int {M_SCAN, M_CONFIRM, M_HOLD, M_RELEASE} mphase_t;
    mphase_t    m_phase = M_SCAN;
    int         m_col   = 0;
    int         m_timer = 0;
    logic [3:0] m_snap  = 4'b0000;
    logic [3:0] m_pipe[$];
    logic [3:0] m_code  = 4'b0000;
    logic       m_valid = 1'b0;
    logic       m_held  = 1'b0;
    logic       m_multi = 1'b0;

    function automatic int lowest_row(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic void model_step(input logic [3:0] rin, input logic rstv);
        logic [3:0] rows;
        if (!rstv) begin
            m_phase = M_SCAN; m_col = 0; m_timer = 0; m_snap = 4'b0000;
            m_code = 4'b0000; m_valid = 1'b0; m_held = 1'b0; m_multi = 1'b0;
            m_pipe = '{4'b0000, 4'b0000};
            return;
        end
        rows = m_pipe.pop_front();
        m_pipe.push_back(rin);
        m_valid = 1'b0;
        case (m_phase)
            M_SCAN: begin
                if (m_timer < DWELL - 1) m_timer++;
                else if (rows != 4'b0000) begin m_snap = rows; m_timer = 0; m_phase = M_CONFIRM; end
                else begin m_col = (m_col + 1) % 4; m_timer = 0; end
            end
            M_CONFIRM: begin
                if (rows != m_snap) begin m_phase = M_SCAN; m_timer = 0; end
                else if (m_timer == DEBOUNCE - 1) begin
                    m_phase = M_HOLD;
                    m_code  = 4'(m_col * 4 + lowest_row(m_snap));
                    m_multi = ($countones(m_snap) > 1);
                    m_valid = 1'b1;
                    m_held  = 1'b1;
                end else m_timer++;
            end
            M_HOLD: begin
                if (rows == 4'b0000) begin m_phase = M_RELEASE; m_timer = 0; end
            end
            M_RELEASE: begin
                if (rows != 4'b0000) begin m_phase = M_HOLD; m_timer = 0; end
                else if (m_timer == DEBOUNCE - 1) begin
                    m_held = 1'b0; m_multi = 1'b0;
                    m_col = (m_col + 1) % 4; m_timer = 0; m_phase = M_SCAN;
                end else m_timer++;
            end
            default: m_phase = M_SCAN;
        endcase
    endfunction

    function automatic logic [12:0] mdl_out();
        return {4'(1 << m_col), 2'(m_col), m_code, m_valid, m_held, m_multi};
    endfunction

    function automatic logic [12:0] dut_out();
        return {kp0.col_drive, kp0.column_index, kp0.key_code,
                kp0.key_valid, kp0.key_held, kp0.multi_key};
    endfunction

    // One clock: sample inputs, advance the model, land on the next negedge.
    task automatic tick();
        #1;
        model_step(kp0.row_in, rst);
        @(posedge slow_clk);
        @(negedge slow_clk);
    endtask

    task automatic clear_keys();
        for (int c = 0; c < 4; c++) keys0[c] = 4'b0000;
        for (int c = 0; c < 3; c++) keys1[c] = 5'b00000;
    endtask

    task automatic do_reset();
        clear_keys();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_keys();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (dut_out() !== 13'b0001_00_0000_0_0_0) begin
            errors++; $display("FAIL reset_dut0: got %b expected %b", dut_out(), 13'b0001_00_0000_0_0_0);
        end
        checks++;
        if ({kp1.col_drive, kp1.column_index, kp1.key_code, kp1.key_valid, kp1.key_held, kp1.multi_key}
            !== 13'b001_00_00000_0_0_0) begin
            errors++; $display("FAIL reset_dut1: got col=%b idx=%0d code=%b v=%b h=%b m=%b",
                kp1.col_drive, kp1.column_index, kp1.key_code, kp1.key_valid, kp1.key_held, kp1.multi_key);
        end
        rst = 1'b1;
    endtask

    task automatic test_idle_sweep();
        int col;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            col = (k / DWELL) % 4;
            checks++;
            if (kp0.column_index !== 2'(col) || kp0.col_drive !== 4'(1 << col) || kp0.key_valid !== 1'b0) begin
                errors++; $display("FAIL idle_sweep: cycle %0d got idx=%0d col=%b v=%b expected idx=%0d col=%b v=0",
                    k, kp0.column_index, kp0.col_drive, kp0.key_valid, col, 4'(1 << col));
            end
            tick();
        end
        checks++;
        if (dut_out() !== mdl_out()) begin
            errors++; $display("FAIL idle_model: got %h expected %h", dut_out(), mdl_out());
        end
    endtask

    task automatic test_clean_press();
        int n;
        int pulses;
        do_reset();
        keys0[2] = 4'b0010;
        n = 0;
        while (kp0.column_index !== 2'd2 && n < 50) begin tick(); n++; end
        n = 0;
        while (kp0.key_valid !== 1'b1 && n < 60) begin tick(); n++; end
        checks++;
        if (n != DWELL + DEBOUNCE) begin
            errors++; $display("FAIL press_latency: got %0d cycles expected %0d", n, DWELL + DEBOUNCE);
        end
        checks++;
        if (kp0.key_code !== 4'b1001 || kp0.key_held !== 1'b1 || kp0.multi_key !== 1'b0) begin
            errors++; $display("FAIL press_code: got code=%b held=%b multi=%b expected 1001 1 0",
                kp0.key_code, kp0.key_held, kp0.multi_key);
        end
        pulses = 0;
        for (int t = 0; t < 40; t++) begin tick(); if (kp0.key_valid === 1'b1) pulses++; end
        checks++;
        if (pulses != 0 || kp0.key_held !== 1'b1) begin
            errors++; $display("FAIL press_hold: got extra_pulses=%0d held=%b expected 0 1", pulses, kp0.key_held);
        end
        keys0[2] = 4'b0000;
        n = 0;
        while (kp0.key_held !== 1'b0 && n < 40) begin tick(); n++; end
        checks++;
        if (n != DEBOUNCE + 3) begin
            errors++; $display("FAIL release_latency: got %0d cycles expected %0d", n, DEBOUNCE + 3);
        end
        checks++;
        if (kp0.column_index !== 2'd3 || kp0.col_drive !== 4'b1000 || kp0.key_code !== 4'b1001) begin
            errors++; $display("FAIL resume_col: got idx=%0d col=%b code=%b expected 3 1000 1001",
                kp0.column_index, kp0.col_drive, kp0.key_code);
        end
        checks++;
        if (dut_out() !== mdl_out()) begin
            errors++; $display("FAIL press_model: got %h expected %h", dut_out(), mdl_out());
        end
    endtask

    task automatic test_bounce();
        int pulses;
        int n;
        do_reset();
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            keys0[0] = (((i / 3) % 2) == 1) ? 4'b0100 : 4'b0000;
            tick();
            if (kp0.key_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL bounce_quiet: got %0d pulses expected 0", pulses);
        end
        keys0[0] = 4'b0100;
        n = 0;
        while (kp0.key_valid !== 1'b1 && n < 80) begin tick(); n++; end
        checks++;
        if (n < DEBOUNCE + 3 || n >= 80 || kp0.key_code !== 4'b0010) begin
            errors++; $display("FAIL bounce_accept: got wait=%0d code=%b expected wait>=%0d code=0010",
                n, kp0.key_code, DEBOUNCE + 3);
        end
        pulses = 0;
        for (int t = 0; t < 20; t++) begin tick(); if (kp0.key_valid === 1'b1) pulses++; end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL bounce_single: got %0d extra pulses expected 0", pulses);
        end
        checks++;
        if (dut_out() !== mdl_out()) begin
            errors++; $display("FAIL bounce_model: got %h expected %h", dut_out(), mdl_out());
        end
    endtask

    task automatic test_release_glitch();
        int n;
        logic dropped;
        logic repulse;
        do_reset();
        keys0[3] = 4'b0001;
        n = 0;
        while (kp0.key_valid !== 1'b1 && n < 60) begin tick(); n++; end
        repeat (5) tick();
        keys0[3] = 4'b0000;
        repeat (8) tick();
        keys0[3] = 4'b0001;
        tick();
        keys0[3] = 4'b0000;
        dropped = 1'b0;
        repulse = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (kp0.key_held !== 1'b1) dropped = 1'b1;
            if (kp0.key_valid === 1'b1) repulse = 1'b1;
        end
        checks++;
        if (dropped !== 1'b0 || repulse !== 1'b0) begin
            errors++; $display("FAIL glitch_hold: got dropped=%b repulse=%b expected 0 0", dropped, repulse);
        end
        n = 0;
        while (kp0.key_held !== 1'b0 && n < 20) begin tick(); n++; end
        checks++;
        if (n >= 20 || kp0.key_code !== 4'b1100) begin
            errors++; $display("FAIL glitch_release: got wait=%0d code=%b expected wait<20 code=1100", n, kp0.key_code);
        end
        checks++;
        if (dut_out() !== mdl_out()) begin
            errors++; $display("FAIL glitch_model: got %h expected %h", dut_out(), mdl_out());
        end
    endtask

    task automatic test_multi_key();
        int n;
        do_reset();
        keys0[1] = 4'b0101;
        n = 0;
        while (kp0.key_valid !== 1'b1 && n < 60) begin tick(); n++; end
        checks++;
        if (kp0.key_valid !== 1'b1 || kp0.key_code !== 4'b0100 || kp0.multi_key !== 1'b1) begin
            errors++; $display("FAIL multi_accept: got v=%b code=%b multi=%b expected 1 0100 1",
                kp0.key_valid, kp0.key_code, kp0.multi_key);
        end
        repeat (4) tick();
        keys0[1] = 4'b0000;
        n = 0;
        while (kp0.key_held !== 1'b0 && n < 40) begin tick(); n++; end
        checks++;
        if (kp0.multi_key !== 1'b0 || kp0.key_code !== 4'b0100 || n >= 40) begin
            errors++; $display("FAIL multi_release: got multi=%b code=%b wait=%0d expected 0 0100 <40",
                kp0.multi_key, kp0.key_code, n);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        keys0[0] = 4'b1000;
        repeat (6) tick();
        rst = 1'b0;
        tick();
        checks++;
        if (dut_out() !== 13'b0001_00_0000_0_0_0) begin
            errors++; $display("FAIL reset_mid_debounce: got %b expected %b", dut_out(), 13'b0001_00_0000_0_0_0);
        end
        rst = 1'b1;
        n = 0;
        while (kp0.key_valid !== 1'b1 && n < 40) begin tick(); n++; end
        repeat (3) tick();
        checks++;
        if (kp0.key_held !== 1'b1 || kp0.key_code !== 4'b0011) begin
            errors++; $display("FAIL reset_mid_reaccept: got held=%b code=%b expected 1 0011", kp0.key_held, kp0.key_code);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (dut_out() !== 13'b0001_00_0000_0_0_0) begin
            errors++; $display("FAIL reset_mid_held: got %b expected %b", dut_out(), 13'b0001_00_0000_0_0_0);
        end
        rst = 1'b1;
        clear_keys();
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 30; it++) begin
            int c;
            int hold;
            int gap;
            c = $urandom_range(0, 3);
            keys0[c] = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 3) == 0) keys0[(c + 1) % 4] = 4'($urandom_range(1, 15));
            hold = $urandom_range(0, 45);
            for (int t = 0; t < hold; t++) begin
                if (t < 8 && $urandom_range(0, 2) == 0) keys0[c] = keys0[c] ^ 4'($urandom_range(0, 15));
                rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
                tick();
                checks++;
                if (dut_out() !== mdl_out()) begin
                    errors++;
                    if (errors < 40) $display("FAIL random_press: t=%0t got %h expected %h", $time, dut_out(), mdl_out());
                end
            end
            rst = 1'b1;
            clear_keys();
            gap = $urandom_range(0, 30);
            for (int t = 0; t < gap; t++) begin
                tick();
                checks++;
                if (dut_out() !== mdl_out()) begin
                    errors++;
                    if (errors < 40) $display("FAIL random_idle: t=%0t got %h expected %h", $time, dut_out(), mdl_out());
                end
            end
        end
    endtask

    task automatic test_alt_config();
        int col;
        int n;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            col = (k / DWELL) % 3;
            checks++;
            if (kp1.column_index !== 2'(col) || kp1.col_drive !== 3'(1 << col) || kp1.key_valid !== 1'b0) begin
                errors++; $display("FAIL alt_sweep: cycle %0d got idx=%0d col=%b v=%b expected idx=%0d col=%b",
                    k, kp1.column_index, kp1.col_drive, kp1.key_valid, col, 3'(1 << col));
            end
            tick();
        end
        keys1[1] = 5'b10000;
        n = 0;
        while (kp1.key_valid !== 1'b1 && n < 60) begin tick(); n++; end
        checks++;
        if (kp1.key_valid !== 1'b1 || kp1.key_code !== {2'd1, 3'd4} || kp1.multi_key !== 1'b0) begin
            errors++; $display("FAIL alt_decode: got v=%b code=%b multi=%b expected 1 01100 0",
                kp1.key_valid, kp1.key_code, kp1.multi_key);
        end
        clear_keys();
        n = 0;
        while (kp1.key_held !== 1'b0 && n < 40) begin tick(); n++; end
        checks++;
        if (kp1.key_held !== 1'b0 || kp1.column_index !== 2'd2) begin
            errors++; $display("FAIL alt_release: got held=%b idx=%0d expected 0 2", kp1.key_held, kp1.column_index);
        end
    endtask

    initial begin
        clear_keys();
        test_reset();
        test_idle_sweep();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_multi_key();
        test_reset_mid();
        test_random();
        test_alt_config();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
Parametrised successor to the 4-column keypad scan shift register. It drives one-hot column strobes over NUM_COLS columns and samples NUM_ROWS row lines through an internal two-flop synchroniser. It adds per-column dwell, press/release debounce, key-code encoding and multi-key detection. It sits between the keypad pins and the operand-entry logic of the Booth multiplier and runs on the 1 kHz slow_clk.

Parameters:
NUM_COLS, 4, number of keypad columns (2..16)
NUM_ROWS, 4, number of keypad rows (2..16)
DWELL, 3, cycles each column is driven before its rows are judged (min 3, covers synchroniser latency)
DEBOUNCE, 10, consecutive stable cycles required to accept a press or a release (min 2)
ROW_ACTIVE_LOW, 0, 1 = row lines read 0 when pressed

Ports:
slow_clk  input  1  scan clock, 1 kHz
rst  input  1  synchronous, active-low reset
row_in  input  NUM_ROWS  raw asynchronous row lines
col_drive  output  NUM_COLS  one-hot column strobe
column_index  output  CW=$clog2(NUM_COLS)  index of the driven column
key_code  output  CW+RW (RW=$clog2(NUM_ROWS))  {column, row} of the accepted key
key_valid  output  1  one-cycle pulse when a debounced press is accepted
key_held  output  1  high from accept until debounced release
multi_key  output  1  more than one row active at accept; valid with key_valid, held with key_held

Behaviour:
- Reset (rst=0 at a slow_clk edge): col_drive=1 (column 0), column_index=0, key_code=0, key_valid=0, key_held=0, multi_key=0. Synchroniser flops clear to the inactive level. Dwell and debounce counters clear to 0. State=SCAN. Reset applied in any state aborts that state with no key_valid.
- Row normalisation: rows = sync2(row_in), inverted when ROW_ACTIVE_LOW=1. hit = |rows.
- SCAN:
  - Dwell counter counts 0..DWELL-1 on the current column.
  - On dwell=DWELL-1 with hit=0: rotate col_drive left by one, column_index+1. Wrap NUM_COLS-1 -> 0 and MSB -> bit 0. Dwell clears.
  - On dwell=DWELL-1 with hit=1: snapshot rows into snap, debounce counter=0, go DEBOUNCE. The column does not advance.
  - hit before DWELL-1 is ignored.
- DEBOUNCE (column frozen):
  - rows==snap: counter+1.
  - rows!=snap: return to SCAN on the same column with dwell=0.
  - Counter reaching DEBOUNCE-1 with rows==snap: go HELD. In that same transition register key_code={column_index, index of lowest set bit of snap}, set multi_key=(popcount(snap)>1), pulse key_valid, set key_held=1.
  - Total latency from first sampled hit to key_valid is DEBOUNCE cycles.
- HELD (column frozen): stay while hit=1, even if the rows pattern changes. No re-pulse and no auto-repeat. hit=0 -> RELEASE with counter=0.
- RELEASE (column frozen):
  - hit=0: counter+1.
  - hit=1: return to HELD with counter cleared, no new key_valid.
  - Counter reaching DEBOUNCE-1: clear key_held and multi_key, advance to the next column (with wrap), dwell=0, go SCAN.
  - key_code holds its last value until the next accept.
- key_valid is high for exactly one cycle per accepted press and never while key_held is already 1.
- Counter widths: $clog2 of the larger of DWELL and DEBOUNCE. Counters saturate and never wrap.

Test Plan:
- Idle sweep, defaults, rows 0: column_index sequence 0,0,0,1,1,1,2,2,2,3,3,3,0…; col_drive 0001->0010->0100->1000->0001; key_valid never asserted.
- Clean press col 2 row 1 held 40 cycles: key_valid pulses once 10 cycles after first sampled hit; key_code=4'b1001; key_held high until 10 cycles after release; scan then resumes at column 3.
- Bounce row toggles every 3 cycles for 20 cycles, then stable: no key_valid during bounce; a single pulse after 10 stable cycles.
- Release glitch: 1-cycle re-press at release count 5 -> returns to HELD; key_held stays 1; no second key_valid.
- Two rows (0 and 2) on column 1 -> key_code=4'b0100, multi_key=1 with key_valid.
- Reset mid-DEBOUNCE and mid-HELD: next cycle col_drive=0001, all outputs 0. NUM_COLS=3, NUM_ROWS=5, ROW_ACTIVE_LOW=1: column wraps 2->0 and row 4 active-low decodes to key_code={2'd1,3'd4}.
